// File: rtl/uart_cmd_wrapper.sv
// 8N1 UART command front end: assembles two received bytes into a 16-bit command
// and shifts a one-byte response back out, receiver and transmitter fully independent.
module uart_cmd_wrapper #(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam int unsigned CW = 16;
  localparam int unsigned BW = 4;
  localparam logic [CW-1:0] BAUD_FULL = CW'(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic { RX_IDLE, RX_RECV } rx_state_e;
  typedef enum logic { ASM_HIGH, ASM_LOW } asm_state_e;
  typedef enum logic { TX_IDLE, TX_XMIT } tx_state_e;

  logic rx_sync1_q, rx_sync2_q;
  rx_state_e rx_state_q, rx_state_d;
  logic [CW-1:0] rx_baud_q, rx_baud_d;
  logic [BW-1:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic byte_vld_c, frame_err_c;

  asm_state_e asm_q, asm_d;
  logic [7:0] high_q, high_d;
  logic [15:0] cmd_q, cmd_d;
  logic rdy_q, rdy_d;

  tx_state_e tx_state_q, tx_state_d;
  logic [CW-1:0] tx_baud_q, tx_baud_d;
  logic [BW-1:0] tx_bit_q, tx_bit_d;
  logic [9:0] tx_shift_q, tx_shift_d;
  logic tx_q, tx_d;
  logic sent_q, sent_d;

  // RX enters through a two-flop synchronizer that idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
    end else begin
      rx_sync1_q <= RX;
      rx_sync2_q <= rx_sync1_q;
    end
  end

  // Receiver: half-bit delay to the start-bit centre, then one sample per bit
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_baud_d   = rx_baud_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    byte_vld_c  = 1'b0;
    frame_err_c = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync2_q) begin
          rx_state_d = RX_RECV;
          rx_baud_d  = BAUD_HALF;
          rx_bit_d   = '0;
        end
      end
      RX_RECV: begin
        if (rx_baud_q == CW'(1)) begin
          rx_baud_d = BAUD_FULL;
          rx_bit_d  = rx_bit_q + BW'(1);
          if (rx_bit_q == BW'(0)) begin
            if (rx_sync2_q) rx_state_d = RX_IDLE;
          end else if (rx_bit_q == BW'(9)) begin
            rx_state_d  = RX_IDLE;
            byte_vld_c  = rx_sync2_q;
            frame_err_c = !rx_sync2_q;
          end else begin
            rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          end
        end else begin
          rx_baud_d = rx_baud_q - CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Byte pairing; a new cmd load takes priority over a same-cycle clear
  always_comb begin
    asm_d  = asm_q;
    high_d = high_q;
    cmd_d  = cmd_q;
    rdy_d  = rdy_q;
    if (clr_cmd_rdy) rdy_d = 1'b0;
    if (frame_err_c) begin
      asm_d = ASM_HIGH;
    end else if (byte_vld_c) begin
      if (asm_q == ASM_HIGH) begin
        high_d = rx_shift_q;
        rdy_d  = 1'b0;
        asm_d  = ASM_LOW;
      end else begin
        cmd_d = {high_q, rx_shift_q};
        rdy_d = 1'b1;
        asm_d = ASM_HIGH;
      end
    end
  end

  // Transmitter: tx_q already holds the bit being driven, so shift_q[1] is next
  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    sent_d     = sent_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (send_resp) begin
          tx_shift_d = {1'b1, resp, 1'b0};
          tx_d       = 1'b0;
          tx_baud_d  = BAUD_LAST;
          tx_bit_d   = '0;
          sent_d     = 1'b0;
          tx_state_d = TX_XMIT;
        end
      end
      TX_XMIT: begin
        if (tx_baud_q == '0) begin
          if (tx_bit_q == BW'(9)) begin
            tx_d       = 1'b1;
            sent_d     = 1'b1;
            tx_state_d = TX_IDLE;
          end else begin
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
            tx_d       = tx_shift_q[1];
            tx_bit_d   = tx_bit_q + BW'(1);
            tx_baud_d  = BAUD_LAST;
          end
        end else begin
          tx_baud_d = tx_baud_q - CW'(1);
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      asm_q      <= ASM_HIGH;
      high_q     <= '0;
      cmd_q      <= '0;
      rdy_q      <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
      tx_q       <= 1'b1;
      sent_q     <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      asm_q      <= asm_d;
      high_q     <= high_d;
      cmd_q      <= cmd_d;
      rdy_q      <= rdy_d;
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      sent_q     <= sent_d;
    end
  end

  assign TX        = tx_q;
  assign cmd       = cmd_q;
  assign cmd_rdy   = rdy_q;
  assign resp_sent = sent_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Scoreboard bench for uart_cmd_wrapper at BAUD_DIV = 16: stimulus pushes expected
// commands / response bytes, independent monitors decode cmd_rdy and the TX line.
module tb_uart_cmd_wrapper;
  localparam int unsigned BD = 16;

  logic        clk;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  int checks   = 0;
  int failures = 0;
  logic [15:0] cmd_exp[$];
  logic [7:0]  tx_exp[$];

  uart_cmd_wrapper #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one 8N1 frame on RX, optionally cut short after maxc cycles
  task automatic rx_frame(input logic [7:0] b, input logic stop, input int maxc);
    logic [9:0] bits;
    int n;
    bits = {stop, b, 1'b0};
    n = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      RX = bits[i];
      for (int j = 0; j < int'(BD); j++) begin
        if (n >= maxc) return;
        @(posedge clk); #1;
        n++;
      end
    end
  endtask

  task automatic pulse_send(input logic [7:0] b);
    @(posedge clk); #1;
    resp = b;
    send_resp = 1'b1;
    @(posedge clk); #1;
    send_resp = 1'b0;
  endtask

  task automatic tx_send(input logic [7:0] b);
    pulse_send(b);
    @(negedge clk);
    chk("tx_start_next_cycle", 16'(TX), 16'h0);
    chk("resp_sent_cleared", 16'(resp_sent), 16'h0);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b1;
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b0;
  endtask

  // Command monitor: every rising cmd_rdy pops one expected command
  initial begin : cmd_mon
    logic prev_rdy;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_rdy = 1'b0;
      end else begin
        if (cmd_rdy && !prev_rdy) begin
          if (cmd_exp.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL cmd_unexpected: got %h expected none", cmd);
          end else begin
            chk("cmd_scoreboard", cmd, cmd_exp.pop_front());
          end
        end
        prev_rdy = cmd_rdy;
      end
    end
  end

  // TX monitor: decode each frame at bit centres and check resp_sent timing
  initial begin : tx_mon
    logic prev_tx;
    logic abort;
    logic [7:0] d;
    int i;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_tx = 1'b1;
      end else if (prev_tx && !TX) begin
        abort = 1'b0;
        d = '0;
        i = 1;
        while (i <= 160 && !abort) begin
          @(negedge clk);
          if (!rst_n) begin
            abort = 1'b1;
          end else begin
            if (i == 7) chk("tx_start_bit", 16'(TX), 16'h0);
            if (i > 7 && i < 151 && (i % 16) == 7) d[i/16 - 1] = TX;
            if (i == 151) chk("tx_stop_bit", 16'(TX), 16'h1);
            if (i == 159) chk("resp_sent_not_early", 16'(resp_sent), 16'h0);
            if (i == 160) begin
              chk("resp_sent_at_160", 16'(resp_sent), 16'h1);
              chk("tx_idle_after_frame", 16'(TX), 16'h1);
              if (tx_exp.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tx_unexpected: got %h expected none", d);
              end else begin
                chk("tx_byte", 16'(d), 16'(tx_exp.pop_front()));
              end
            end
          end
          i++;
        end
      end
      prev_tx = TX;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t;
    rst_n = 1'b0;
    RX = 1'b1;
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    resp = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 16'(TX), 16'h1);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_cmd_rdy", 16'(cmd_rdy), 16'h0);
    chk("rst_resp_sent", 16'(resp_sent), 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Two bytes form a command; clear leaves cmd intact
    cmd_exp.push_back(16'h4001);
    rx_frame(8'h40, 1'b1, 1000);
    rx_frame(8'h01, 1'b1, 1000);
    chk("cmd_4001", cmd, 16'h4001);
    chk("cmd_rdy_set", 16'(cmd_rdy), 16'h1);
    pulse_clr();
    chk("cmd_rdy_cleared", 16'(cmd_rdy), 16'h0);
    chk("cmd_kept_after_clr", cmd, 16'h4001);

    // Response frame with an ignored second request mid-flight
    tx_exp.push_back(8'hA5);
    tx_send(8'hA5);
    repeat (37) @(posedge clk);
    pulse_send(8'h3C);
    repeat (140) @(posedge clk);
    #1;
    chk("resp_sent_held", 16'(resp_sent), 16'h1);

    // High byte alone leaves cmd; framing error re-arms for a high byte
    cmd_exp.push_back(16'h6022);
    rx_frame(8'h11, 1'b1, 1000);
    chk("cmd_unchanged_by_high", cmd, 16'h4001);
    rx_frame(8'h6B, 1'b0, 1000);
    @(posedge clk); #1;
    RX = 1'b1;
    repeat (32) @(posedge clk);
    rx_frame(8'h60, 1'b1, 1000);
    rx_frame(8'h22, 1'b1, 1000);
    chk("cmd_6022", cmd, 16'h6022);

    // Start-bit glitch, then a load coinciding with a clear
    @(posedge clk); #1;
    RX = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    RX = 1'b1;
    repeat (32) @(posedge clk);
    cmd_exp.push_back(16'h4BF1);
    rx_frame(8'h4B, 1'b1, 1000);
    fork
      rx_frame(8'hF1, 1'b1, 1000);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #1 clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1 clr_cmd_rdy = 1'b0;
      end
    join
    chk("set_wins_over_clr", 16'(cmd_rdy), 16'h1);
    chk("cmd_4BF1", cmd, 16'h4BF1);

    // Reset during a second RX byte and a TX frame
    rx_frame(8'h12, 1'b1, 1000);
    tx_send(8'hC3);
    rx_frame(8'h34, 1'b1, 80);
    rst_n = 1'b0;
    RX = 1'b1;
    tx_exp.delete();
    #1;
    chk("midrst_tx", 16'(TX), 16'h1);
    chk("midrst_cmd", cmd, 16'h0000);
    chk("midrst_cmd_rdy", 16'(cmd_rdy), 16'h0);
    chk("midrst_resp_sent", 16'(resp_sent), 16'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    cmd_exp.push_back(16'h57F2);
    rx_frame(8'h57, 1'b1, 1000);
    rx_frame(8'hF2, 1'b1, 1000);
    chk("cmd_57F2", cmd, 16'h57F2);

    // Full duplex
    tx_exp.push_back(8'h5A);
    cmd_exp.push_back(16'h53F2);
    fork
      tx_send(8'h5A);
      begin
        rx_frame(8'h53, 1'b1, 1000);
        rx_frame(8'hF2, 1'b1, 1000);
      end
    join
    chk("cmd_53F2", cmd, 16'h53F2);

    t = 0;
    while ((cmd_exp.size() != 0 || tx_exp.size() != 0) && t < 400) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    chk("cmd_queue_drained", 16'(cmd_exp.size()), 16'h0);
    chk("tx_queue_drained", 16'(tx_exp.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_wrapper.md
UART_CMD_WRAPPER -- requirements
Module: uart_cmd_wrapper

Interface
REQ-001 SHALL have parameter: BAUD_DIV, 5208, clk cycles per UART bit (50 MHz / 9600 baud); legal range 8..65535.
REQ-002 SHALL have port: clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: RX  input  1  serial command line from the remote; idles high; asynchronous to clk.
REQ-005 SHALL have port: TX  output  1  serial response line to the remote; idles high.
REQ-006 SHALL have port: cmd  output  16  last assembled command, {first byte, second byte}.
REQ-007 SHALL have port: cmd_rdy  output  1  level; a new cmd is valid.
REQ-008 SHALL have port: clr_cmd_rdy  input  1  single-cycle pulse from the consumer; clears cmd_rdy.
REQ-009 SHALL have port: resp  input  8  response byte to transmit (e.g. 8'hA5 ack).
REQ-010 SHALL have port: send_resp  input  1  single-cycle pulse; start transmitting resp.
REQ-011 SHALL have port: resp_sent  output  1  level; last response frame fully shifted out.

Function
REQ-012 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1, each bit BAUD_DIV cycles.
REQ-013 RX SHALL pass through a 2-flop synchronizer, both flops reset to 1; only the synchronized value is used.
REQ-014 Receiver FSM SHALL have states IDLE and RECV.
- IDLE -> RECV on synchronized RX = 0.
- Baud counter SHALL be loaded with BAUD_DIV/2 on that edge, then with BAUD_DIV after each sample.
- Sampling SHALL give 10 samples: start, 8 data, stop.
REQ-015 Start sample = 1 (glitch) SHALL return the receiver to IDLE with no byte delivered.
REQ-016 Stop sample = 0 (framing error) SHALL discard the byte and reset the byte assembler to expect a high byte.
REQ-017 Byte assembler SHALL have states HIGH and LOW and reset to HIGH.
- Valid byte in HIGH: store it in a high-byte register, clear cmd_rdy, go to LOW.
- Valid byte in LOW: load cmd = {high, byte}, go to HIGH.
REQ-018 cmd_rdy SHALL assert the cycle after the second byte's stop sample.
- It SHALL hold until clr_cmd_rdy or until the next valid high byte arrives.
- If clr_cmd_rdy and the cmd load happen in the same cycle, set SHALL win.
REQ-019 cmd SHALL change only at the second-byte load; the high byte alone SHALL NOT alter cmd.
REQ-020 Transmitter FSM SHALL have states IDLE and XMIT.
- send_resp in IDLE: latch {1, resp, 0} into a 10-bit shift register, clear resp_sent, go to XMIT.
- Bits SHALL shift out LSB first, one per BAUD_DIV cycles.
REQ-021 TX SHALL drive the start bit the cycle after send_resp.
REQ-022 After the 10th bit period the transmitter SHALL set resp_sent, return to IDLE and drive TX = 1.
REQ-023 send_resp during XMIT SHALL be ignored; the frame in flight SHALL NOT be corrupted and resp_sent SHALL stay 0.
REQ-024 Receiver and transmitter SHALL run independently (full duplex), so simultaneous RX and TX activity SHALL produce correct frames on both.
REQ-025 Counters SHALL be sized for BAUD_DIV up to 65535 (16-bit baud, 4-bit bit count); no wrap shall occur inside a frame.

Reset
REQ-026 rst_n low SHALL immediately force these values, regardless of any frame in progress:
- TX = 1, cmd = 16'h0000, cmd_rdy = 0, resp_sent = 0;
- receiver IDLE, assembler HIGH, transmitter IDLE;
- synchronizer flops = 1, counters = 0.
REQ-027 After rst_n release, a partially received frame SHALL NOT produce a byte; reception SHALL restart at the next falling edge of RX.

Verification (BAUD_DIV = 16)
REQ-028 Send bytes 8'h40 then 8'h01 on RX.
- cmd = 16'h4001 and cmd_rdy = 1 one cycle after the second stop sample.
- Pulse clr_cmd_rdy: cmd_rdy = 0 and cmd unchanged.
REQ-029 Pulse send_resp with resp = 8'hA5.
- TX = 0 the next cycle, then 1,0,1,0,0,1,0,1 (8'hA5 LSB first), then 1 for 16 cycles each.
- resp_sent = 1 after 160 cycles.
- A second send_resp at cycle 40 SHALL be ignored.
REQ-030 Send 8'h6B with stop bit forced 0, then 8'h60, 8'h22: cmd = 16'h6022 and no cmd containing 8'h6B.
REQ-031 Drive RX low for 4 cycles only: no byte, assembler still HIGH; then 8'h4B, 8'hF1: cmd = 16'h4BF1.
REQ-032 Assert rst_n low mid-way through the second RX byte and mid-way through a TX frame.
- Outputs at reset values within the same cycle; TX = 1.
- Then 8'h57, 8'hF2: cmd = 16'h57F2.
REQ-033 Transmit 8'h5A while receiving 8'h53, 8'hF2: TX bits match 8'h5A, and cmd = 16'h53F2.
